// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle RV32 control FSM (IF/ID/EX/MEM/WB/TRAP) with retired-instruction counter.
// Define ILLEGAL_TRAP_EN to halt in TRAP on an illegal opcode; otherwise illegal opcodes retire as uncounted NOPs.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      instr,
  output logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             zero,
  output logic [1:0]       ALUOp,
  output logic             ALUSrc,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [31:0]      IR,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic [CNT_W-1:0] instret,
  output logic             trap
);

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP} state_t;

  state_t state;

  logic [6:0] opcode;
  logic is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_br, legal, retire;

  assign opcode  = IR[6:0];
  assign funct3  = IR[14:12];
  assign funct7  = IR[31:25];
  assign is_r    = (opcode == 7'b0110011);
  assign is_addi = (opcode == 7'b0010011);
  assign is_lw   = (opcode == 7'b0000011);
  assign is_sw   = (opcode == 7'b0100011);
  assign is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
  assign is_bne  = (opcode == 7'b1100011) && (funct3 == 3'b001);
  assign is_br   = is_beq || is_bne;
  assign legal   = is_r || is_addi || is_lw || is_sw || is_br;

  // Retirement points: branch resolve in EX, store ack in MEM, every WB.
  assign retire = ((state == S_EX) && is_br) ||
                  ((state == S_MEM) && is_sw && dmem_ack) ||
                  (state == S_WB);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IF;
      IR      <= '0;
      instret <= '0;
    end else begin
      if (retire) instret <= instret + CNT_W'(1);
      case (state)
        S_IF: begin
          if (imem_ack) begin
            IR    <= instr;
            state <= S_ID;
          end
        end
        S_ID: begin
          if (legal) state <= S_EX;
          else begin
`ifdef ILLEGAL_TRAP_EN
            state <= S_TRAP;
`else
            state <= S_IF;
`endif
          end
        end
        S_EX: begin
          if (is_br)               state <= S_IF;
          else if (is_lw || is_sw) state <= S_MEM;
          else                     state <= S_WB;
        end
        S_MEM:   if (dmem_ack) state <= is_lw ? S_WB : S_IF;
        S_WB:    state <= S_IF;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_IF;
      endcase
    end
  end

  // Strobes and requests are forced low while reset is asserted, so a same-cycle ack cannot retire anything.
  // NOTE: every output gets a default before the case, so no path leaves a latch behind.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    ALUOp    = 2'b00;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    if (rst_n) begin
      case (state)
        S_IF: imem_req = 1'b1;
        S_ID: begin
`ifndef ILLEGAL_TRAP_EN
          PCWrite = !legal;
`endif
        end
        S_EX: begin
          ALUSrc = is_addi || is_lw || is_sw;
          if (is_r) ALUOp = 2'b10;
          else if (is_br) begin
            ALUOp   = 2'b01;
            PCWrite = 1'b1;
            PCSrc   = (is_beq && zero) || (is_bne && !zero);
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          MemRead  = is_lw;
          MemWrite = is_sw;
          PCWrite  = is_sw && dmem_ack;
        end
        S_WB: begin
          RegWrite = 1'b1;
          MemtoReg = is_lw;
          PCWrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign trap = (state == S_TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule
